multiword_adder_ctrl: RTL and testbench
=======================================

# multiword_adder_ctrl

Sequencer that computes WIDTH-bit add/subtract results by time-multiplexing one 16-bit ripple carry adder over WIDTH/16 cycles. The carry is held in a flop between chunks. It sits between a requester (ALU or test harness) and the 16-bit adder datapath. It trades latency for area on wide operands and uses a start/done handshake.

## Interface
- WIDTH, default 64: operand/result width; multiple of 16, ≥ 16.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- in1  input  WIDTH  operand A; captured on the accepted start edge.
- in2  input  WIDTH  operand B; captured on the accepted start edge.
- c_in  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0: A+B+c_in; 1: A−B (A + ~B + 1); captured with operands.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register.
- c_out  output  1  carry out of bit WIDTH−1; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Three states: IDLE, RUN, DONE. NCHUNK = WIDTH/16.
- IDLE with start=1:
  - Latch A=in1 and B=(sub ? ~in2 : in2).
  - Set carry flop = (sub ? 1 : c_in) and chunk counter k=0.
  - Go to RUN.
- IDLE with start=0: stay; sum/c_out/ovf hold their last values.
- Each RUN cycle:
  - The adder sees A[16k+15:16k], B[16k+15:16k] and the carry flop.
  - Its 16-bit sum is written to sum[16k+15:16k]; its carry-out is written to the carry flop.
  - k increments.
  - Shift-register operand/result implementation is acceptable if cycle behaviour is identical.
- After chunk NCHUNK−1: c_out = final carry; ovf = (A[W−1]==B[W−1]) && (sum[W−1]!=A[W−1]), using the latched, possibly inverted B. Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE. There is no queueing; the requester must re-assert start in IDLE.
- Input changes after acceptance have no effect on the operation in progress.
- sum upper chunks hold stale data during RUN. The result is guaranteed only while done=1, and it persists through IDLE until the next accepted start.
- rst_n low at any time, including mid-RUN:
  - Immediately forces IDLE.
  - busy=0, done=0, sum=0, c_out=0, ovf=0; k=0; carry flop=0.
  - The aborted operation never produces done.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0, ovf=0, state IDLE.
- Edge E0 samples start=1 in IDLE. E1..E_NCHUNK each commit one chunk. done is high between E_NCHUNK and E_NCHUNK+1.
- Latency from start edge to done: NCHUNK+1 rising edges, i.e. 5 for WIDTH=64 and 2 for WIDTH=16.
- Throughput: one operation per NCHUNK+2 cycles. Earliest next accept is the first IDLE edge after DONE.
- busy rises the cycle after E0 and falls the cycle after done.
- The combinational path per cycle is one 16-bit ripple chain plus mux/flop setup; no path spans chunks.

## Structure
- Shared include/package holds:
  - CHUNK_W = 16.
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 decodes to IDLE).
  - Counter width macro: clog2 of the maximum NCHUNK.
- One sub-module: the existing RippleCarryAdder_16bit instantiated once as the datapath. No other adders are permitted.
- Elaboration-time check: WIDTH % 16 == 0.

## Test plan
- Carry crossing a chunk boundary. WIDTH=64, in1=0x0000_0000_FFFF_FFFF, in2=1, c_in=0, sub=0 → sum=0x0000_0001_0000_0000, c_out=0, ovf=0. done high exactly 5 edges after the start edge, for 1 cycle.
- Full wrap. in1=0xFFFF_FFFF_FFFF_FFFF, in2=0, c_in=1 → sum=0, c_out=1, ovf=0.
- Subtract with borrow. sub=1, in1=5, in2=7, c_in=1 (ignored) → sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0, ovf=0. Then in1=7, in2=5 → sum=2, c_out=1.
- Signed overflow. in1=0x7FFF_FFFF_FFFF_FFFF, in2=1, sub=0 → sum=0x8000_0000_0000_0000, ovf=1, c_out=0.
- Start during busy. Accept in1=3, in2=4; then assert start with in1=100 and change inputs during RUN → single done, sum=7, busy continuous. Then start on the first IDLE cycle after done → second result correct.
- Mid-operation reset. rst_n low after E2 of a 64-bit op → busy/done/sum/c_out/ovf read 0 without waiting for a clock edge; no done after release. The next operation (in1=1, in2=1) → sum=2.

Source files
------------

// File: rtl/multiword_adder_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the multi-word adder sequencer.
package multiword_adder_ctrl_pkg;

    localparam int CHUNK_W    = 16;
    localparam int MAX_WIDTH  = 1024;
    localparam int MAX_NCHUNK = MAX_WIDTH / CHUNK_W;
    localparam int CNT_W      = $clog2(MAX_NCHUNK);

    // 2'd3 is not listed; the sequencer decodes it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement overflow from the sign bits of both addends and the sum.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/multiword_adder_ctrl_rca16.sv
// 16-bit ripple-carry adder: the single datapath adder shared by every chunk.
module multiword_adder_ctrl_rca16
    import multiword_adder_ctrl_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               ci,
    output logic [CHUNK_W-1:0] s,
    output logic               co
);

    // Propagate the carry bit by bit from LSB to MSB.
    always_comb begin
        logic c;
        s = '0;
        c = ci;
        for (int i = 0; i < CHUNK_W; i++) begin
            // NOTE: blocking assignments are intentional here; each bit must see the carry just computed for the bit below.
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/multiword_adder_ctrl.sv
// Computes a WIDTH-bit add/subtract by running one 16-bit adder over WIDTH/16 cycles.
module multiword_adder_ctrl
    import multiword_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int               NCHUNK     = WIDTH / CHUNK_W;
    localparam logic [CNT_W-1:0] LAST_K     = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK_W{1'b1}});

    if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("multiword_adder_ctrl: WIDTH must be a multiple of 16 in [16, MAX_WIDTH]");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic               carry_q, carry_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic [31:0]        bit_off;
    logic [CHUNK_W-1:0] chunk_a, chunk_b, chunk_s;
    logic               chunk_co;

    // Pick chunk k of the latched operands for the shared adder.
    always_comb begin
        bit_off = 32'(k_q) * CHUNK_W;
        chunk_a = CHUNK_W'(a_q >> bit_off);
        chunk_b = CHUNK_W'(b_q >> bit_off);
    end

    multiword_adder_ctrl_rca16 u_rca16 (
        .a  (chunk_a),
        .b  (chunk_b),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // Next-state and datapath updates for IDLE / RUN / DONE.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_RUN: begin
                sum_d   = (sum_q & ~(CHUNK_MASK << bit_off)) | (WIDTH'(chunk_s) << bit_off);
                carry_d = chunk_co;
                k_d     = k_q + CNT_W'(1);
                if (k_q == LAST_K) begin
                    c_out_d = chunk_co;
                    ovf_d   = signed_ovf(chunk_a[CHUNK_W-1], chunk_b[CHUNK_W-1], chunk_s[CHUNK_W-1]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin  // ST_IDLE and the unused encoding
                if (start) begin
                    a_d     = in1;
                    b_d     = sub ? ~in2 : in2;
                    carry_d = sub ? 1'b1 : c_in;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // State, operand, carry and result registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Self-checking bench for multiword_adder_ctrl (WIDTH=64): directed vectors plus a
// transaction-level model checked against the DUT every cycle.
module tb_multiword_adder_ctrl;

    localparam int W      = 64;
    localparam int NCHUNK = W / 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, c_out, ovf;
    logic [W-1:0] sum;

    int n_vec = 0;
    int n_err = 0;

    multiword_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .c_in  (c_in),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result from whole-word arithmetic: {ovf, c_out, sum}.
    function automatic logic [W+1:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic ci, input logic s);
        logic [W:0]          u;
        logic signed [W+1:0] sa, sb, r;
        logic                v;
        u  = {1'b0, a} + {1'b0, (s ? ~b : b)} + (W+1)'(s ? 1'b1 : ci);
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        r  = s ? (sa - sb) : (sa + sb + (W+2)'(ci));
        v  = (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
        return {v, u[W], u[W-1:0]};
    endfunction

    // Transaction model: m_left counts edges until the op retires (0 = idle).
    int           m_left = 0;
    logic [W-1:0] pend_sum = '0, exp_sum = '0;
    logic         pend_c = 1'b0, exp_c = 1'b0, pend_ovf = 1'b0, exp_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            exp_sum <= '0;
            exp_c   <= 1'b0;
            exp_ovf <= 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= NCHUNK + 1;
                {pend_ovf, pend_c, pend_sum} <= model_result(in1, in2, c_in, sub);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                exp_sum <= pend_sum;
                exp_c   <= pend_c;
                exp_ovf <= pend_ovf;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_busy", W'(busy), W'(m_left != 0));
        check("cyc_done", W'(done), W'(m_left == 1));
        if (m_left <= 1) begin
            check("cyc_sum", sum, exp_sum);
            check("cyc_c_out", W'(c_out), W'(exp_c));
            check("cyc_ovf", W'(ovf), W'(exp_ovf));
        end
    end

    // One operation; inputs are scrambled after acceptance. poke re-asserts start during RUN.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic s, input bit poke,
                         input logic [W-1:0] x_sum, input logic x_c, input logic x_ovf);
        int edges;
        @(posedge clk); #1;
        start = 1'b1; in1 = a; in2 = b; c_in = ci; sub = s;
        @(posedge clk); edges = 1; #1;
        start = poke;
        in1   = poke ? W'(100) : {$urandom, $urandom};
        in2   = {$urandom, $urandom};
        c_in  = ~ci;
        sub   = ~s;
        while (done !== 1'b1 && edges < 20) begin
            @(posedge clk); edges++; #1;
            start = poke && (edges < NCHUNK + 1);
            if (poke) begin
                in1 = W'(100);
                in2 = {$urandom, $urandom};
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, W'(edges), W'(NCHUNK + 1));
        check({tag, "_sum"}, sum, x_sum);
        check({tag, "_c_out"}, W'(c_out), W'(x_c));
        check({tag, "_ovf"}, W'(ovf), W'(x_ovf));
    endtask

    initial begin
        int done_cnt;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_sum", sum, '0);
        check("rst_c_out", W'(c_out), '0);
        check("rst_ovf", W'(ovf), '0);
        rst_n = 1'b1;

        do_op("carry_cross", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0,
              64'h0000_0001_0000_0000, 1'b0, 1'b0);
        do_op("full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b0,
              64'h0, 1'b1, 1'b0);
        do_op("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_pos", 64'd7, 64'd5, 1'b1, 1'b1, 1'b0,
              64'd2, 1'b1, 1'b0);
        do_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1);
        do_op("start_busy", 64'd3, 64'd4, 1'b0, 1'b0, 1'b1,
              64'd7, 1'b0, 1'b0);
        do_op("back2back", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b0,
              64'h2222_2222_2222_2211, 1'b0, 1'b0);

        // Abort an operation after its second chunk commits.
        @(posedge clk); #1;
        start = 1'b1; in1 = 64'h1111_1111_1111_1111; in2 = 64'h2222_2222_2222_2222;
        c_in = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", W'(busy), '0);
        check("abort_done", W'(done), '0);
        check("abort_sum", sum, '0);
        check("abort_c_out", W'(c_out), '0);
        check("abort_ovf", W'(ovf), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", W'(done_cnt), '0);

        do_op("after_abort", 64'd1, 64'd1, 1'b0, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
